umi_regfile_endpoint: RTL and testbench

- UMI request sink that sits directly downstream of the flexible-width UMI FIFO. It consumes that FIFO's narrow output stream, which is 32 bits wide by default.
- Decodes single-beat read, write and posted requests against a small bank of 32-bit registers.
- Returns UMI responses on a separate output channel and exposes register contents to surrounding logic.
- Serves as the standard terminating agent for FIFO/bridge benches and for simple control/status blocks.

---
 rtl/umi_pkg.sv | 52 +++++
 rtl/umi_cmd_decode.sv | 24 ++
 rtl/umi_regfile_endpoint.sv | 221 ++++++++++++++++++++++
 tb/tb_umi_regfile_endpoint.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
// Shared UMI definitions for request/response endpoints.
//   - Request/response opcode values.
//   - Bit positions and widths of the command fields.
//   - Response error codes carried in cmd[26:25].
//   - A packed struct holding the decoded command fields.
package umi_pkg;

  // Opcodes
  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  // Command field positions
  localparam int UMI_OPCODE_LSB = 0;
  localparam int UMI_OPCODE_W   = 5;
  localparam int UMI_SIZE_LSB   = 5;
  localparam int UMI_SIZE_W     = 3;
  localparam int UMI_LEN_LSB    = 8;
  localparam int UMI_LEN_W      = 8;
  localparam int UMI_QOS_LSB    = 16;
  localparam int UMI_QOS_W      = 4;
  localparam int UMI_PROT_LSB   = 20;
  localparam int UMI_PROT_W     = 2;
  localparam int UMI_EOM_BIT    = 22;
  localparam int UMI_EOF_BIT    = 23;
  localparam int UMI_RSVD_BIT   = 24;
  localparam int UMI_ERR_LSB    = 25;
  localparam int UMI_ERR_W      = 2;
  localparam int UMI_HOSTID_LSB = 27;
  localparam int UMI_HOSTID_W   = 5;

  // Response error codes
  localparam logic [1:0] UMI_ERR_OK  = 2'b00;
  localparam logic [1:0] UMI_ERR_SLV = 2'b10;
  localparam logic [1:0] UMI_ERR_DEC = 2'b11;

  typedef struct packed {
    logic [UMI_HOSTID_W-1:0] hostid;
    logic [UMI_ERR_W-1:0]    err;
    logic                    rsvd;
    logic                    eof;
    logic                    eom;
    logic [UMI_PROT_W-1:0]   prot;
    logic [UMI_QOS_W-1:0]    qos;
    logic [UMI_LEN_W-1:0]    len;
    logic [UMI_SIZE_W-1:0]   size;
    logic [UMI_OPCODE_W-1:0] opcode;
  } umi_cmd_t;

endpackage

// File: rtl/umi_cmd_decode.sv
// Combinational UMI command field extractor.
//   cmd    : raw command word (CW bits, fields live in the low 32)
//   fields : decoded command fields
module umi_cmd_decode
  import umi_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic [CW-1:0] cmd,
  output umi_cmd_t      fields
);

  assign fields.opcode = cmd[UMI_OPCODE_LSB +: UMI_OPCODE_W];
  assign fields.size   = cmd[UMI_SIZE_LSB +: UMI_SIZE_W];
  assign fields.len    = cmd[UMI_LEN_LSB +: UMI_LEN_W];
  assign fields.qos    = cmd[UMI_QOS_LSB +: UMI_QOS_W];
  assign fields.prot   = cmd[UMI_PROT_LSB +: UMI_PROT_W];
  assign fields.eom    = cmd[UMI_EOM_BIT];
  assign fields.eof    = cmd[UMI_EOF_BIT];
  assign fields.rsvd   = cmd[UMI_RSVD_BIT];
  assign fields.err    = cmd[UMI_ERR_LSB +: UMI_ERR_W];
  assign fields.hostid = cmd[UMI_HOSTID_LSB +: UMI_HOSTID_W];

endmodule

// File: rtl/umi_regfile_endpoint.sv
// UMI request sink terminating single-beat READ / WRITE / POSTED requests
// against a bank of NREGS 32-bit registers.
//   clk, reset        : clock, synchronous active-high reset
//   umi_in_*          : request channel (valid/ready)
//   umi_out_*         : response channel (valid/ready), single output register
//   regs_out          : flattened register contents, reg i at [32i+31:32i]
//   err_count         : saturating count of rejected/unsupported requests
module umi_regfile_endpoint
  import umi_pkg::*;
#(
  parameter int             DW    = 32,
  parameter int             AW    = 64,
  parameter int             CW    = 32,
  parameter int             NREGS = 16,
  parameter logic [AW-1:0]  BASE  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                umi_in_valid,
  input  logic [CW-1:0]       umi_in_cmd,
  input  logic [AW-1:0]       umi_in_dstaddr,
  input  logic [AW-1:0]       umi_in_srcaddr,
  input  logic [DW-1:0]       umi_in_data,
  output logic                umi_in_ready,
  output logic                umi_out_valid,
  output logic [CW-1:0]       umi_out_cmd,
  output logic [AW-1:0]       umi_out_dstaddr,
  output logic [AW-1:0]       umi_out_srcaddr,
  output logic [DW-1:0]       umi_out_data,
  input  logic                umi_out_ready,
  output logic [32*NREGS-1:0] regs_out,
  output logic [15:0]         err_count
);

  // Register index width and the number of low address bits spanned by the bank
  localparam int IDXW = $clog2(NREGS);
  localparam int OFFW = IDXW + 2;

  // Decoded request
  umi_cmd_t req;

  umi_cmd_decode #(
    .CW (CW)
  ) u_cmd_decode (
    .cmd    (umi_in_cmd),
    .fields (req)
  );

  // Output stage state
  logic          out_valid_reg;
  logic [CW-1:0] out_cmd_reg;
  logic [AW-1:0] out_dstaddr_reg;
  logic [AW-1:0] out_srcaddr_reg;
  logic [DW-1:0] out_data_reg;
  logic [15:0]   err_count_reg;
  logic [15:0]   err_count_next;

  // Request classification
  logic            accept;
  logic            is_read;
  logic            is_write;
  logic            is_posted;
  logic            misaligned;
  logic            slv_err;
  logic            dec_err;
  logic            req_ok;
  logic            count_err;
  logic            wr_en;
  logic [IDXW-1:0] reg_idx;
  logic [1:0]      byte_off;
  logic [1:0]      resp_err;
  logic [CW-1:0]   resp_cmd;

  // Byte-lane datapath
  logic [3:0]  size_lanes;
  logic [3:0]  byte_mask;
  logic [31:0] wr_bit_mask;
  logic [31:0] rd_bit_mask;
  logic [31:0] wr_bits;
  logic [31:0] sel_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_data;

  // A response can be loaded whenever the output register is empty or draining
  assign umi_in_ready = !out_valid_reg || umi_out_ready;
  assign accept       = umi_in_valid && umi_in_ready;

  assign is_read   = (req.opcode == UMI_REQ_READ);
  assign is_write  = (req.opcode == UMI_REQ_WRITE);
  assign is_posted = (req.opcode == UMI_REQ_POSTED);

  assign reg_idx  = umi_in_dstaddr[OFFW-1:2];
  assign byte_off = umi_in_dstaddr[1:0];

  // Size legality and natural alignment; sizes above 4 bytes are never legal
  always_comb begin
    misaligned = 1'b1;
    size_lanes = 4'b0000;
    case (req.size)
      3'd0: begin
        misaligned = 1'b0;
        size_lanes = 4'b0001;
      end
      3'd1: begin
        misaligned = umi_in_dstaddr[0];
        size_lanes = 4'b0011;
      end
      3'd2: begin
        misaligned = |umi_in_dstaddr[1:0];
        size_lanes = 4'b1111;
      end
      default: begin
        misaligned = 1'b1;
        size_lanes = 4'b0000;
      end
    endcase
  end

  assign slv_err = (req.len != '0) || misaligned;

  // BASE is aligned to the bank span, so range check is an upper-bit compare
  assign dec_err = (umi_in_dstaddr[AW-1:OFFW] != BASE[AW-1:OFFW]);

  assign req_ok    = !slv_err && !dec_err;
  assign count_err = !(is_read || is_write || is_posted) || !req_ok;
  assign wr_en     = accept && (is_write || is_posted) && req_ok;

  assign resp_err = slv_err ? UMI_ERR_SLV :
                    dec_err ? UMI_ERR_DEC : UMI_ERR_OK;

  // Byte lanes: write lanes start at the byte offset, data enters from lane 0
  assign byte_mask = size_lanes << byte_off;
  assign wr_bits   = umi_in_data << {byte_off, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_bit_mask[8*gi +: 8] = {8{byte_mask[gi]}};
      assign rd_bit_mask[8*gi +: 8] = {8{size_lanes[gi]}};
    end
  endgenerate

  // Register bank; each register is its own flop group so regs_out is free
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [31:0] value_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          value_reg <= '0;
        end else if (wr_en && (reg_idx == IDXW'(gi))) begin
          value_reg <= (value_reg & ~wr_bit_mask) | (wr_bits & wr_bit_mask);
        end
      end

      assign regs_out[32*gi +: 32] = value_reg;
    end
  endgenerate

  // Read path: pre-write register value, shifted down and trimmed to size
  assign sel_word = regs_out[32*reg_idx +: 32];
  assign rd_shift = sel_word >> {byte_off, 3'b000};
  assign rd_data  = rd_shift & rd_bit_mask;

  // Response command: request attributes echoed, eom forced, error code set
  always_comb begin
    resp_cmd = '0;
    resp_cmd[UMI_OPCODE_LSB +: UMI_OPCODE_W] = is_read ? UMI_RESP_READ : UMI_RESP_WRITE;
    resp_cmd[UMI_SIZE_LSB +: UMI_SIZE_W]     = req.size;
    resp_cmd[UMI_LEN_LSB +: UMI_LEN_W]       = req.len;
    resp_cmd[UMI_QOS_LSB +: UMI_QOS_W]       = req.qos;
    resp_cmd[UMI_PROT_LSB +: UMI_PROT_W]     = req.prot;
    resp_cmd[UMI_EOM_BIT]                    = 1'b1;
    resp_cmd[UMI_EOF_BIT]                    = req.eof;
    resp_cmd[UMI_ERR_LSB +: UMI_ERR_W]       = resp_err;
    resp_cmd[UMI_HOSTID_LSB +: UMI_HOSTID_W] = req.hostid;
  end

  always_comb begin
    err_count_next = err_count_reg;
    if (accept && count_err && (err_count_reg != 16'hFFFF)) begin
      err_count_next = err_count_reg + 16'd1;
    end
  end

  // Output register: loads on an accepted READ/WRITE, otherwise holds until
  // the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_cmd_reg     <= '0;
      out_dstaddr_reg <= '0;
      out_srcaddr_reg <= '0;
      out_data_reg    <= '0;
      err_count_reg   <= '0;
    end else begin
      if (accept && (is_read || is_write)) begin
        out_valid_reg   <= 1'b1;
        out_cmd_reg     <= resp_cmd;
        out_dstaddr_reg <= umi_in_srcaddr;
        out_srcaddr_reg <= umi_in_dstaddr;
        out_data_reg    <= (is_read && req_ok) ? rd_data : '0;
      end else if (umi_out_ready) begin
        out_valid_reg <= 1'b0;
      end
      err_count_reg <= err_count_next;
    end
  end

  assign umi_out_valid   = out_valid_reg;
  assign umi_out_cmd     = out_cmd_reg;
  assign umi_out_dstaddr = out_dstaddr_reg;
  assign umi_out_srcaddr = out_srcaddr_reg;
  assign umi_out_data    = out_data_reg;
  assign err_count       = err_count_reg;

  // Request fields that a response never reflects
  logic unused_req_bits;
  assign unused_req_bits = ^{req.eom, req.rsvd, req.err};

endmodule

// File: tb/tb_umi_regfile_endpoint.sv
module tb_umi_regfile_endpoint;

  localparam int          DW    = 32;
  localparam int          AW    = 64;
  localparam int          CW    = 32;
  localparam int          NREGS = 16;
  localparam logic [63:0] BASE  = 64'h0;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                umi_in_valid = 1'b0;
  logic [CW-1:0]       umi_in_cmd = '0;
  logic [AW-1:0]       umi_in_dstaddr = '0;
  logic [AW-1:0]       umi_in_srcaddr = '0;
  logic [DW-1:0]       umi_in_data = '0;
  logic                umi_in_ready;
  logic                umi_out_valid;
  logic [CW-1:0]       umi_out_cmd;
  logic [AW-1:0]       umi_out_dstaddr;
  logic [AW-1:0]       umi_out_srcaddr;
  logic [DW-1:0]       umi_out_data;
  logic                umi_out_ready = 1'b1;
  logic [32*NREGS-1:0] regs_out;
  logic [15:0]         err_count;

  always #5 clk = ~clk;

  umi_regfile_endpoint #(
    .DW    (DW),
    .AW    (AW),
    .CW    (CW),
    .NREGS (NREGS),
    .BASE  (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .regs_out        (regs_out),
    .err_count       (err_count)
  );

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_regs [NREGS];
  int          model_errs = 0;
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int          req_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: applies one accepted request in order of acceptance
  task automatic model_req(input logic [31:0] cmd, input logic [63:0] dst,
                           input logic [63:0] src, input logic [31:0] data);
    int          opc, size, len, nb, off, idx;
    logic [1:0]  err;
    logic [31:0] rd;
    logic [31:0] rc;
    resp_t       r;
    opc  = int'(cmd[4:0]);
    size = int'(cmd[7:5]);
    len  = int'(cmd[15:8]);
    rd   = 32'h0;
    err  = 2'b00;
    if (len != 0 || size > 2 || (dst % (64'd1 << size)) != 0) err = 2'b10;
    else if (dst < BASE || dst >= BASE + 64'(4 * NREGS)) err = 2'b11;
    if (opc == 1 || opc == 3 || opc == 5) begin
      if (err != 2'b00) begin
        model_errs++;
      end else begin
        nb  = 1 << size;
        off = int'(dst[1:0]);
        idx = int'((dst - BASE) >> 2);
        for (int k = 0; k < nb; k++) begin
          if (opc == 1) rd[8*k +: 8] = model_regs[idx][8*(off+k) +: 8];
          else          model_regs[idx][8*(off+k) +: 8] = data[8*k +: 8];
        end
      end
      if (opc == 1 || opc == 3) begin
        rc = 32'h0;
        rc[4:0]   = (opc == 1) ? 5'h02 : 5'h04;
        rc[7:5]   = cmd[7:5];
        rc[15:8]  = cmd[15:8];
        rc[19:16] = cmd[19:16];
        rc[21:20] = cmd[21:20];
        rc[22]    = 1'b1;
        rc[23]    = cmd[23];
        rc[26:25] = err;
        rc[31:27] = cmd[31:27];
        r.cmd  = rc;
        r.dst  = src;
        r.src  = dst;
        r.data = (opc == 1 && err == 2'b00) ? rd : 32'h0;
        exp_q.push_back(r);
      end
    end else begin
      model_errs++;
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NREGS; i++) check($sformatf("reg%0d", i), regs_out[32*i +: 32], model_regs[i]);
    check("err_count", err_count, model_errs);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_req(input logic [31:0] cmd, input logic [63:0] dst,
                          input logic [63:0] src, input logic [31:0] data, output int waited);
    bit done;
    umi_in_valid   = 1'b1;
    umi_in_cmd     = cmd;
    umi_in_dstaddr = dst;
    umi_in_srcaddr = src;
    umi_in_data    = data;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (umi_in_ready) begin
        model_req(cmd, dst, src, data);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 500) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: request cmd=%h not accepted after %0d cycles", cmd, waited);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    umi_in_valid = 1'b0;
    req_n++;
    $display("req %0d: cmd=%h dst=%h data=%h waited=%0d", req_n, cmd, dst, data, waited);
    check_state();
  endtask

  function automatic logic [31:0] mk_cmd(input logic [4:0] opc, input logic [2:0] size,
                                         input logic [7:0] len, input logic [31:0] extra);
    logic [31:0] c;
    c = extra;
    c[4:0]  = opc;
    c[7:5]  = size;
    c[15:8] = len;
    return c;
  endfunction

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || umi_out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
    end
  endtask

  task automatic random_traffic(input int count);
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [2:0]  size;
    logic [4:0]  opc;
    logic [7:0]  len;
    int          r, idx, off, w;
    for (int t = 0; t < count; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      opc = 5'h01;
      else if (r < 7) opc = 5'h03;
      else if (r < 9) opc = 5'h05;
      else            opc = 5'($urandom);
      size = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
      r = $urandom_range(0, 19);
      if (r < 16) begin
        idx = $urandom_range(0, NREGS - 1);
        off = $urandom_range(0, 3);
        if (size <= 3'd2) off = off & ~((1 << size) - 1);
        dst = BASE + 64'(idx * 4 + off);
      end else if (r < 18) begin
        dst = BASE + 64'($urandom_range(0, 4 * NREGS - 1));
      end else if (r == 18) begin
        dst = BASE + 64'(4 * NREGS);
      end else begin
        dst = {$urandom, $urandom};
      end
      cmd = mk_cmd(opc, size, len, $urandom);
      send_req(cmd, dst, {$urandom, $urandom}, $urandom, w);
    end
  endtask

  // Response ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       umi_out_ready = 1'b1;
        2:       umi_out_ready = 1'b0;
        default: umi_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected responses and checks payload stability under stall
  initial begin
    resp_t       e;
    bit          held;
    logic [31:0] h_cmd, h_data;
    logic [63:0] h_dst, h_src;
    int          resp_n;
    held   = 1'b0;
    resp_n = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else if (umi_out_valid) begin
        if (held) begin
          check("stall_cmd", umi_out_cmd, h_cmd);
          check("stall_dst", umi_out_dstaddr, h_dst);
          check("stall_src", umi_out_srcaddr, h_src);
          check("stall_data", umi_out_data, h_data);
        end
        if (umi_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got cmd=%h data=%h with no response expected", umi_out_cmd, umi_out_data);
          end else begin
            e = exp_q.pop_front();
            resp_n++;
            check("resp_cmd", umi_out_cmd, e.cmd);
            check("resp_dst", umi_out_dstaddr, e.dst);
            check("resp_src", umi_out_srcaddr, e.src);
            check("resp_data", umi_out_data, e.data);
            $display("resp %0d: cmd=%h dst=%h data=%h", resp_n, umi_out_cmd, umi_out_dstaddr, umi_out_data);
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_cmd  = umi_out_cmd;
          h_dst  = umi_out_dstaddr;
          h_src  = umi_out_srcaddr;
          h_data = umi_out_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", umi_out_valid, 0);
    check("rst_in_ready", umi_in_ready, 1);
    check("rst_out_cmd", umi_out_cmd, 0);
    check("rst_out_data", umi_out_data, 0);
    check_state();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Posted 32-bit write then read back
    send_req(mk_cmd(5'h05, 3'd2, 8'h0, 32'h0), BASE + 64'd4, 64'hAAAA_0000_0000_0001, 32'hDEADBEEF, w);
    check("posted_reg1", regs_out[63:32], 32'hDEADBEEF);
    send_req(mk_cmd(5'h01, 3'd2, 8'h0, 32'h5A00_0000), BASE + 64'd4, 64'h1234_5678_9ABC_DEF0, 32'h0, w);

    // Byte write into the middle of reg1, then halfword read of the top half
    send_req(mk_cmd(5'h03, 3'd0, 8'h0, 32'h0), BASE + 64'd6, 64'h0000_0000_0000_0042, 32'h0000_00A5, w);
    check("byte_reg1", regs_out[63:32], 32'hDEA5BEEF);
    send_req(mk_cmd(5'h01, 3'd1, 8'h0, 32'h0), BASE + 64'd6, 64'h0000_0000_0000_0043, 32'h0, w);

    // Out-of-range read (DECERR) and misaligned halfword read (SLVERR)
    send_req(mk_cmd(5'h01, 3'd2, 8'h0, 32'h0), BASE + 64'(4 * NREGS), 64'h99, 32'h0, w);
    check("decerr_count", err_count, 16'd1);
    send_req(mk_cmd(5'h01, 3'd1, 8'h0, 32'h0), BASE + 64'd1, 64'h9A, 32'h0, w);
    check("slverr_count", err_count, 16'd2);
    drain();

    // Output stall with a second read waiting at the input
    rdy_mode = 2;
    send_req(mk_cmd(5'h01, 3'd2, 8'h0, 32'h0), BASE + 64'd4, 64'hB001, 32'h0, w);
    fork
      send_req(mk_cmd(5'h01, 3'd0, 8'h0, 32'h0), BASE + 64'd7, 64'hB002, 32'h0, w2);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", umi_in_ready, 0);
          check("stall_out_valid", umi_out_valid, 1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();

    // Back-to-back write/read under continuous ready
    send_req(mk_cmd(5'h03, 3'd2, 8'h0, 32'h0), BASE + 64'd12, 64'hC001, 32'h1, w);
    check("b2b_write_wait", w, 0);
    send_req(mk_cmd(5'h01, 3'd2, 8'h0, 32'h0), BASE + 64'd12, 64'hC002, 32'h0, w);
    check("b2b_read_wait", w, 0);
    drain();

    // Randomised traffic with random backpressure
    rdy_mode = 1;
    random_traffic(300);
    drain();

    // Reset while a response is stalled
    rdy_mode = 2;
    send_req(mk_cmd(5'h01, 3'd2, 8'h0, 32'h0), BASE + 64'd4, 64'hD001, 32'h0, w);
    check("pre_rst_valid", umi_out_valid, 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    model_errs = 0;
    check("midrst_out_valid", umi_out_valid, 0);
    check("midrst_in_ready", umi_in_ready, 1);
    check("midrst_out_dst", umi_out_dstaddr, 0);
    check_state();
    reset = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    rdy_mode = 1;
    random_traffic(60);
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
